// File: rtl/goofy_arb_pkg.sv
// rtl/goofy_arb_pkg.sv - shared types and constants for the goofy memory arbiter
// Contents: state_t (IDLE=0, ACCESS=1, RESP=2), NUM_REQ, requester indices,
//           one-hot <-> index helpers.
package goofy_arb_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_EXEC  = 2'd1;
  localparam logic [1:0] REQ_DEBUG = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = REQ_FETCH;
    case (oh)
      3'b010:  idx = REQ_EXEC;
      3'b100:  idx = REQ_DEBUG;
      default: idx = REQ_FETCH;
    endcase
    return idx;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    case (idx)
      REQ_EXEC:  oh = 3'b010;
      REQ_DEBUG: oh = 3'b100;
      default:   oh = 3'b001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/goofy_arb_pick.sv
// rtl/goofy_arb_pick.sv - combinational winner selection for the memory arbiter
// Ports: req [2:0] in  - pending requests
//        ptr [1:0] in  - index of the last granted requester
//        win [2:0] out - one-hot winner, zero when no request
// Macro GOOFY_ARB_RR_EN: round-robin from ptr+1 (mod 3); otherwise fixed 0 > 1 > 2.
module goofy_arb_pick
  import goofy_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] win
);

  function automatic logic [NUM_REQ-1:0] lowest(input logic [NUM_REQ-1:0] x);
    return x & (~x + 3'd1);
  endfunction

`ifdef GOOFY_ARB_RR_EN
  // Rotate so the search start sits in bit 0, take the lowest set bit,
  // then rotate the result back to requester positions.
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] p;

  always_comb begin
    rot = req;
    p   = '0;
    win = '0;
    case (ptr)
      2'd0: begin
        rot = {req[0], req[2], req[1]};
        p   = lowest(rot);
        win = {p[1], p[0], p[2]};
      end
      2'd1: begin
        rot = {req[1], req[0], req[2]};
        p   = lowest(rot);
        win = {p[0], p[2], p[1]};
      end
      default: begin
        rot = req;
        p   = lowest(rot);
        win = p;
      end
    endcase
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign win        = lowest(req);
`endif

endmodule

// File: rtl/goofy_mem_arbiter.sv
// rtl/goofy_mem_arbiter.sv - three-requester single-port RAM arbiter
// Ports: clk, res (async active-low)
//        req/we [2:0], addr [3*ADDR_W], wdata [3*DATA_W] - requester side, slice i = requester i
//        gnt [2:0]  - one-hot grant, asserted in the IDLE cycle that wins
//        rvalid [2:0], rdata - one-hot completion and read data in RESP
//        ram_save, ram_addr, ram_in, ram_out - synchronous RAM side (1-cycle read latency)
//        busy - high outside IDLE
// Macro GOOFY_ARB_RR_EN: adds the last-grant pointer and round-robin selection.
module goofy_mem_arbiter
  import goofy_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_save,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_in,
  input  logic [DATA_W-1:0]         ram_out,
  output logic                      busy
);

  state_t             state_q;
  state_t             state_d;
  logic               armed_q;   // set by the first clock edge after reset; gates gnt
  logic [1:0]         idx_q;
  logic               we_q;
  logic               load;
  logic [NUM_REQ-1:0] win;
  logic [1:0]         win_idx;
  logic [1:0]         ptr;

`ifdef GOOFY_ARB_RR_EN
  logic [1:0] last_grant_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      last_grant_q <= REQ_DEBUG;
    end else if (load) begin
      last_grant_q <= win_idx;
    end
  end

  assign ptr = last_grant_q;
`else
  assign ptr = REQ_DEBUG;
`endif

  goofy_arb_pick u_pick (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  assign win_idx = onehot_to_idx(win);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      idx_q    <= REQ_FETCH;
      we_q     <= 1'b0;
      ram_addr <= '0;
      ram_in   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (load) begin
        idx_q    <= win_idx;
        we_q     <= we[win_idx];
        ram_addr <= addr[win_idx*ADDR_W +: ADDR_W];
        ram_in   <= wdata[win_idx*DATA_W +: DATA_W];
      end
    end
  end

  // All handshake outputs decode from state so an async reset clears them at once.
  always_comb begin
    state_d  = state_q;
    gnt      = '0;
    rvalid   = '0;
    rdata    = '0;
    ram_save = 1'b0;
    busy     = 1'b1;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (armed_q && (|req)) begin
          gnt     = win;
          load    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ram_save = we_q;
        state_d  = RESP;
      end
      RESP: begin
        rvalid  = idx_to_onehot(idx_q);
        rdata   = we_q ? '0 : ram_out;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_goofy_mem_arbiter.sv
// tb/tb_goofy_mem_arbiter.sv - self-checking bench for goofy_mem_arbiter
module tb_goofy_mem_arbiter;

  logic        clk;
  logic        res;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [47:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [7:0]  rdata;
  logic        ram_save;
  logic [15:0] ram_addr;
  logic [7:0]  ram_in;
  logic [7:0]  ram_out;
  logic        busy;

  goofy_mem_arbiter dut (
    .clk      (clk),
    .res      (res),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ram_save (ram_save),
    .ram_addr (ram_addr),
    .ram_in   (ram_in),
    .ram_out  (ram_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (ram_save) ram[ram_addr] <= ram_in;
    ram_out <= ram[ram_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // requester-side stimulus
  logic [2:0]  pend;
  logic [2:0]  p_we;
  logic [15:0] p_addr [3];
  logic [7:0]  p_data [3];
  bit          sticky;

  // reference model
  logic [7:0]  model_mem [0:65535];
  int          model_slot;   // -1 idle, else cycles since grant (0,1,2)
  int          model_last;
  bit          model_armed;
  int          t_idx;
  bit          t_we;
  logic [15:0] t_addr;
  logic [7:0]  t_data;

  logic [2:0]  gnt_log [$];
  logic [2:0]  last_rv;
  logic [7:0]  last_rd;

  function automatic int model_pick(input logic [2:0] r, input int last);
`ifdef GOOFY_ARB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (r[i]) return i;
    end
`else
    for (int k = 0; k < 3; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'h0010;
      2:       return 16'hFFFF;
      3:       return 16'hFFFE;
      default: return 16'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic model_reset();
    model_slot  = -1;
    model_last  = 2;
    model_armed = 0;
  endtask

  task automatic drive();
    req   = pend;
    we    = p_we;
    addr  = {p_addr[2], p_addr[1], p_addr[0]};
    wdata = {p_data[2], p_data[1], p_data[0]};
  endtask

  task automatic cycle_check(output int w);
    logic [2:0] eg;
    logic [2:0] ev;
    w  = -1;
    eg = '0;
    if (model_slot < 0 && model_armed && req != 3'b000) begin
      w          = model_pick(req, model_last);
      eg         = 3'b001 << w;
      t_idx      = w;
      t_we       = we[w];
      t_addr     = p_addr[w];
      t_data     = p_data[w];
      model_slot = 0;
      model_last = w;
    end
    ev = (model_slot == 2) ? (3'b001 << t_idx) : 3'b000;
    check("gnt", 32'(gnt), 32'(eg));
    check("busy", 32'(busy), 32'(model_slot > 0));
    check("ram_save", 32'(ram_save), 32'(model_slot == 1 && t_we));
    check("rvalid", 32'(rvalid), 32'(ev));
    if (model_slot == 1) begin
      check("ram_addr", 32'(ram_addr), 32'(t_addr));
      if (t_we) check("ram_in", 32'(ram_in), 32'(t_data));
    end
    if (model_slot == 2) begin
      if (t_we) check("rdata_wr", 32'(rdata), 32'h0);
      else      check("rdata_rd", 32'(rdata), 32'(model_mem[t_addr]));
    end
    if (model_slot == 1 && t_we) model_mem[t_addr] = t_data;
    if (model_slot == 2)      model_slot = -1;
    else if (model_slot >= 0) model_slot++;
    model_armed = 1;
  endtask

  // Called at posedge+1; applies inputs, checks at negedge, returns at next posedge+1.
  task automatic step();
    int w;
    drive();
    @(negedge clk);
    cycle_check(w);
    if (gnt != 3'b000)    gnt_log.push_back(gnt);
    if (rvalid != 3'b000) begin
      last_rv = rvalid;
      last_rd = rdata;
    end
    if (w >= 0 && !sticky) pend[w] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && model_slot >= 0; k++) step();
    check("drain_idle", 32'(busy), 32'h0);
  endtask

  task automatic do_reset(input int ncyc);
    res = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      drive();
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check("rst_rdata", 32'(rdata), 32'h0);
      check("rst_ram_save", 32'(ram_save), 32'h0);
      check("rst_ram_addr", 32'(ram_addr), 32'h0);
      check("rst_ram_in", 32'(ram_in), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
    end
    model_reset();
  endtask

  task automatic set_req(input int i, input bit w_en, input logic [15:0] a, input logic [7:0] d);
    pend[i]   = 1'b1;
    p_we[i]   = w_en;
    p_addr[i] = a;
    p_data[i] = d;
  endtask

  logic [2:0] exp_seq [3];
  int         n2;

  initial begin
`ifdef GOOFY_ARB_RR_EN
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
`else
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b001; exp_seq[2] = 3'b001;
`endif
    for (int a = 0; a < 65536; a++) begin
      ram[a]       = 8'h00;
      model_mem[a] = 8'h00;
    end
    clk    = 1'b0;
    res    = 1'b0;
    sticky = 0;
    pend   = 3'b111;
    p_we   = 3'b000;
    for (int i = 0; i < 3; i++) begin
      p_addr[i] = 16'h0;
      p_data[i] = 8'h0;
    end
    last_rv = '0;
    last_rd = '0;
    model_reset();
    drive();
    @(posedge clk);
    #1;

    // reset with all requests asserted: outputs must stay quiet
    do_reset(3);

    // write by requester 0, released in the same cycle
    pend = 3'b000;
    set_req(0, 1, 16'h0010, 8'hA5);
    res = 1'b1;
    gnt_log.delete();
    step();
    check("r034_no_gnt_c0", 32'(gnt_log.size()), 32'd0);
    step();
    check("r034_gnt_c1", 32'(gnt_log.size()), 32'd1);
    drain();
    check("r034_ram", 32'(ram[16'h0010]), 32'hA5);

    // read back by requester 1
    set_req(1, 0, 16'h0010, 8'h00);
    drain_start: step();
    drain();
    check("r035_rvalid", 32'(last_rv), 32'b010);
    check("r035_rdata", 32'(last_rd), 32'hA5);

    // debug request raised and withdrawn while busy
    gnt_log.delete();
    set_req(0, 0, 16'hFFFF, 8'h00);
    step();
    set_req(2, 1, 16'h0020, 8'h5A);
    step();
    pend[2] = 1'b0;
    step();
    step();
    step();
    n2 = 0;
    foreach (gnt_log[k]) if (gnt_log[k][2]) n2++;
    check("r039_no_gnt2", 32'(n2), 32'd0);
    check("r039_no_ram", 32'(ram[16'h0020]), 32'h00);

    // all three requesting for 9 cycles straight after reset
    do_reset(2);
    for (int i = 0; i < 3; i++) set_req(i, 0, rand_addr(), 8'h00);
    sticky = 1;
    res = 1'b1;
    gnt_log.delete();
    for (int k = 0; k < 9; k++) step();
    sticky = 0;
    pend = 3'b000;
    drain();
    check("seq_count", 32'(gnt_log.size()), 32'd3);
    for (int k = 0; k < 3 && k < gnt_log.size(); k++)
      check($sformatf("seq_gnt%0d", k), 32'(gnt_log[k]), 32'(exp_seq[k]));

    // reset in the ACCESS cycle of a write
    set_req(0, 1, 16'h0040, 8'h77);
    step();
    #1;
    check("r038_save_before", 32'(ram_save), 32'h1);
    res = 1'b0;
    #1;
    check("r038_save_dropped", 32'(ram_save), 32'h0);
    check("r038_busy_dropped", 32'(busy), 32'h0);
    check("r038_rvalid", 32'(rvalid), 32'h0);
    @(posedge clk);
    #1;
    do_reset(2);
    check("r038_no_write", 32'(ram[16'h0040]), 32'h00);
    set_req(0, 1, 16'h0030, 8'h3C);
    res = 1'b1;
    gnt_log.delete();
    step();
    check("r038_no_gnt_c0", 32'(gnt_log.size()), 32'd0);
    step();
    check("r038_gnt_c1", 32'(gnt_log.size()), 32'd1);
    drain();
    set_req(2, 0, 16'h0040, 8'h00);
    step();
    drain();
    check("r038_read_rvalid", 32'(last_rv), 32'b100);
    check("r038_read_rdata", 32'(last_rd), 32'h00);

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
        end else begin
          p_we[i]   = 1'($urandom_range(0, 1));
          p_addr[i] = 16'($urandom);
          p_data[i] = 8'($urandom);
        end
      end
      step();
    end
    pend = 3'b000;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/goofy_mem_arbiter.md
GOOFY_MEM_ARBITER -- requirements
Module: goofy_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port res  input  1  asynchronous active-low reset; the block is in reset while res=0.
REQ-005 The block SHALL have port req  input  3  per-requester access request (bit 0 = fetch, 1 = exec data, 2 = debug).
REQ-006 The block SHALL have port we  input  3  per-requester write enable (1 = write, 0 = read).
REQ-007 The block SHALL have port addr  input  3*ADDR_W  per-requester address; requester i occupies slice [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port wdata  input  3*DATA_W  per-requester write data, packed the same way as addr.
REQ-009 The block SHALL have port gnt  output  3  one-hot, one-cycle grant pulse.
REQ-010 The block SHALL have port rvalid  output  3  one-hot, one-cycle completion pulse (read data valid or write acknowledged).
REQ-011 The block SHALL have port rdata  output  DATA_W  read data, meaningful only while rvalid is non-zero.
REQ-012 The block SHALL have port ram_save  output  1  RAM write strobe.
REQ-013 The block SHALL have port ram_addr  output  ADDR_W  RAM address.
REQ-014 The block SHALL have port ram_in  output  DATA_W  RAM write data.
REQ-015 The block SHALL have port ram_out  input  DATA_W  RAM read data, valid one cycle after ram_addr is presented.
REQ-016 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
- IDLE -> ACCESS when any req bit is 1.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-018 In the IDLE cycle that has a pending request, the block SHALL pulse gnt for the winner and register that requester's index, we, addr and wdata into ram_addr/ram_in/ram_save.
REQ-019 In ACCESS, ram_save SHALL equal the latched we for exactly one cycle; ram_save SHALL be 0 in every other state.
REQ-020 In RESP, the block SHALL pulse rvalid[winner] and drive rdata from ram_out for reads; for writes it SHALL pulse rvalid[winner] with rdata=0.
REQ-021 Each access SHALL take 3 cycles from grant to completion, so the block accepts at most one access per 3 cycles and never starts a new grant before RESP ends.
REQ-022 A requester SHALL hold req, we, addr and wdata stable until gnt; inputs after gnt SHALL be ignored.
REQ-023 A req bit that drops before gnt SHALL withdraw the request with no side effect.
REQ-024 Without round-robin, winner selection SHALL be fixed priority: 0 > 1 > 2.
REQ-025 A request that arrives while busy=1 SHALL wait and SHALL be arbitrated in the next IDLE cycle.
REQ-026 The block SHALL perform no address arithmetic; addresses pass through unchanged at full ADDR_W (0xFFFF is legal and does not wrap).

Reset
REQ-027 While res=0, the block SHALL asynchronously force state=IDLE and gnt, rvalid, rdata, ram_save, ram_addr, ram_in and busy to 0, and set the round-robin pointer to 2.
REQ-028 An in-flight access SHALL be dropped on reset with no rvalid; a write interrupted in ACCESS SHALL have ram_save deasserted immediately.
REQ-029 After res rises, the first grant SHALL occur no earlier than the first rising clk edge.

Configuration
REQ-030 With GOOFY_ARB_RR_EN defined, the winner SHALL be the first requesting index searching upward (mod 3) from last_grant+1, and last_grant SHALL update at each grant.
REQ-031 With GOOFY_ARB_RR_EN undefined, the pointer register SHALL be absent and REQ-024 priority SHALL apply.

Structure
REQ-032 Package goofy_arb_pkg SHALL hold the state encoding (IDLE=0, ACCESS=1, RESP=2), NUM_REQ=3 and the requester index constants.
REQ-033 A sub-module goofy_arb_pick SHALL implement the combinational winner selection (req, pointer -> one-hot winner); all sequencing SHALL stay in goofy_mem_arbiter.

Verification
REQ-034 Reset release, then a write by requester 0 (req=001, we=001, addr0=0x0010, wdata0=0xA5) -> gnt=001 at cycle 1, ram_save=1 only at cycle 2, rvalid=001 at cycle 3.
REQ-035 A read by requester 1 of 0x0010 after REQ-034 -> rvalid=010 with rdata=0xA5 exactly 2 cycles after gnt.
REQ-036 Fixed-priority build with req=111 held for 9 cycles -> grants 001, 001, 001 (requester 0 always wins).
REQ-037 GOOFY_ARB_RR_EN build with req=111 held for 9 cycles -> grants 001, 010, 100 in rotation.
REQ-038 res=0 asserted during ACCESS of a write -> ram_save=0 immediately, no rvalid, and after release the next grant follows REQ-034 timing.
REQ-039 req2 raised for 1 cycle while busy=1, then dropped -> no gnt[2] and no RAM access.
